// File: rtl/modmul_prod_seq.sv
// -----------------------------------------------------------------------------
// modmul_prod_seq
//
// Iterative shift-add multiplier producing the 24-bit raw product A*B that
// feeds the combinational mod-3329 reducer. It consumes RADIX_BITS bits of B
// per cycle, LSB slice first, so one product takes CYCLES = 12/RADIX_BITS
// accumulation cycles. Operands are taken with a valid/ready handshake, and the
// product is held with its tag until the downstream side accepts it.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset; aborts any operation in flight
//   in_valid   operand pair valid
//   in_ready   block can accept an operand pair (IDLE only)
//   in_a       multiplicand A, 12 bits
//   in_b       multiplier B, 12 bits
//   in_tag     sideband tag, returned unchanged with the product
//   out_valid  product valid (OUT state)
//   out_ready  downstream accepts the product
//   out_c      product A*B, 24 bits; changes only on entry to OUT or on reset
//   out_tag    tag latched with the operands
//   busy       high while accumulating (MUL state)
// -----------------------------------------------------------------------------
module modmul_prod_seq #(
  parameter int RADIX_BITS = 1,
  parameter int TAG_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [11:0]      in_a,
  input  logic [11:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [23:0]      out_c,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  // Only radices that divide 12 evenly give a whole number of cycles.
  if (!(RADIX_BITS == 1 || RADIX_BITS == 2 || RADIX_BITS == 3 ||
        RADIX_BITS == 4 || RADIX_BITS == 6 || RADIX_BITS == 12)) begin : g_bad_radix
    $error("modmul_prod_seq: RADIX_BITS must be one of 1, 2, 3, 4, 6, 12");
  end

  localparam int CYCLES = 12 / RADIX_BITS;
  localparam int CNT_W  = $clog2(CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_OUT
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [23:0]        out_c_q, out_c_d;
  logic [TAG_W-1:0]   out_tag_q, out_tag_d;

  // Working operands: A is pre-shifted by cnt*RADIX_BITS and B is shifted
  // right, so the current slice is always B's low RADIX_BITS bits. This is the
  // same sum as indexing B[cnt*RADIX_BITS +: RADIX_BITS] without a variable
  // part-select or barrel shifter.
  logic [23:0]        a_sh_q, a_sh_d;
  logic [11:0]        b_sh_q, b_sh_d;
  logic [23:0]        acc_q, acc_d;
  logic [TAG_W-1:0]   tag_q, tag_d;

  logic [23:0]        pp;
  logic [23:0]        acc_sum;

  // Product never exceeds 4095*4095 = 0xFFE001, so 24 bits never overflow.
  assign pp      = a_sh_q * 24'(b_sh_q[RADIX_BITS-1:0]);
  assign acc_sum = acc_q + pp;

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    out_c_d   = out_c_q;
    out_tag_d = out_tag_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    acc_d     = acc_q;
    tag_d     = tag_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_sh_d  = {12'd0, in_a};
          b_sh_d  = in_b;
          tag_d   = in_tag;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_MUL;
        end
      end

      S_MUL: begin
        busy   = 1'b1;
        acc_d  = acc_sum;
        a_sh_d = a_sh_q << RADIX_BITS;
        b_sh_d = b_sh_q >> RADIX_BITS;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          // Result registers load only here, so out_c/out_tag stay put
          // through OUT and afterwards until the next product.
          out_c_d   = acc_sum;
          out_tag_d = tag_q;
          state_d   = S_OUT;
        end
      end

      S_OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Control and visible result registers: reset clears them so that no
  // partial product is ever presented after an abort.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      out_c_q   <= '0;
      out_tag_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      out_c_q   <= out_c_d;
      out_tag_q <= out_tag_d;
    end
  end

  // NOTE: the working operand/accumulator registers carry no reset; they are
  // always reloaded on accept before being used, and are never visible.
  always_ff @(posedge clk) begin
    a_sh_q <= a_sh_d;
    b_sh_q <= b_sh_d;
    acc_q  <= acc_d;
    tag_q  <= tag_d;
  end

  assign out_c   = out_c_q;
  assign out_tag = out_tag_q;

endmodule

// File: tb/tb_modmul_prod_seq.sv
// -----------------------------------------------------------------------------
// tb_modmul_prod_seq
//
// Directed bench for modmul_prod_seq. Two instances share the clock, reset and
// operand buses: dut1 (RADIX_BITS=1, 12 cycles) and dut4 (RADIX_BITS=4,
// 3 cycles); each has its own in_valid/out_ready so only one is driven at a
// time. Inputs change and outputs are sampled 1 time unit after the edge.
// -----------------------------------------------------------------------------
module tb_modmul_prod_seq;

  localparam int Q = 3329;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] in_a, in_b;
  logic [7:0]  in_tag;

  logic        in_valid1, in_ready1, out_valid1, out_ready1, busy1;
  logic [23:0] out_c1;
  logic [7:0]  out_tag1;

  logic        in_valid4, in_ready4, out_valid4, out_ready4, busy4;
  logic [23:0] out_c4;
  logic [7:0]  out_tag4;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  modmul_prod_seq #(.RADIX_BITS(1), .TAG_W(8)) dut1 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid1), .in_ready(in_ready1),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .out_c(out_c1), .out_tag(out_tag1), .busy(busy1)
  );

  modmul_prod_seq #(.RADIX_BITS(4), .TAG_W(8)) dut4 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid4), .in_ready(in_ready4),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .out_c(out_c4), .out_tag(out_tag4), .busy(busy4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operand pair to the selected instance, wait for the accept
  // edge, then count cycles until out_valid rises (bounded).
  task automatic run_op(input int sel, input logic [11:0] a, input logic [11:0] b,
                        input logic [7:0] t, output int lat);
    int guard;
    in_a = a; in_b = b; in_tag = t;
    if (sel == 1) in_valid1 = 1'b1; else in_valid4 = 1'b1;
    guard = 0;
    while (!((sel == 1) ? in_ready1 : in_ready4) && guard < 100) begin
      tick();
      guard++;
    end
    tick();
    in_valid1 = 1'b0;
    in_valid4 = 1'b0;
    lat = 0;
    while (!((sel == 1) ? out_valid1 : out_valid4) && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [11:0] ra, rb;
    logic [23:0] exp_c;
    logic [11:0] a5 [8];
    logic [11:0] b5 [8];
    logic [23:0] exp_q [$];
    logic [7:0]  exp_t [$];
    int          idx, got, cyc, last_acc;
    logic        acc_now, hs_now;

    reset = 1'b1;
    in_valid1 = 1'b0; in_valid4 = 1'b0;
    out_ready1 = 1'b1; out_ready4 = 1'b1;
    in_a = '0; in_b = '0; in_tag = '0;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    check("rst_out_valid", 32'(out_valid1), 0);
    check("rst_out_c",     32'(out_c1), 0);
    check("rst_out_tag",   32'(out_tag1), 0);
    check("rst_busy",      32'(busy1), 0);
    check("rst_in_ready",  32'(in_ready1), 1);

    // 1: 3328*3328, radix 1
    run_op(1, 12'd3328, 12'd3328, 8'h11, lat);
    check("t1_latency", 32'(lat), 12);
    check("t1_out_c",   32'(out_c1), 32'hA90000);
    check("t1_out_tag", 32'(out_tag1), 32'h11);
    check("t1_mod_q",   32'(out_c1) % Q, 1);
    tick();
    check("t1_valid_drop", 32'(out_valid1), 0);
    check("t1_in_ready",   32'(in_ready1), 1);

    // 2: extremes, radix 1 then radix 4
    run_op(1, 12'd4095, 12'd4095, 8'h22, lat);
    check("t2_r1_max_lat", 32'(lat), 12);
    check("t2_r1_max_c",   32'(out_c1), 32'hFFE001);
    tick();
    run_op(1, 12'd0, 12'd2731, 8'h23, lat);
    check("t2_r1_zero_c",   32'(out_c1), 0);
    check("t2_r1_zero_tag", 32'(out_tag1), 32'h23);
    tick();
    run_op(4, 12'd4095, 12'd4095, 8'h24, lat);
    check("t2_r4_max_lat", 32'(lat), 3);
    check("t2_r4_max_c",   32'(out_c4), 32'hFFE001);
    check("t2_r4_max_tag", 32'(out_tag4), 32'h24);
    tick();
    run_op(4, 12'd0, 12'd2731, 8'h25, lat);
    check("t2_r4_zero_lat", 32'(lat), 3);
    check("t2_r4_zero_c",   32'(out_c4), 0);
    tick();

    // 3: backpressure for 20 cycles; 1234*567 = 699678
    out_ready1 = 1'b0;
    run_op(1, 12'd1234, 12'd567, 8'h33, lat);
    check("t3_latency", 32'(lat), 12);
    for (int i = 0; i < 20; i++) begin
      in_valid1 = i[0];
      in_a = 12'(i * 37); in_b = 12'(i * 11 + 5); in_tag = 8'(i);
      tick();
      check("t3_hold_valid", 32'(out_valid1), 1);
      check("t3_hold_c",     32'(out_c1), 699678);
      check("t3_hold_tag",   32'(out_tag1), 32'h33);
      check("t3_in_ready",   32'(in_ready1), 0);
    end
    in_valid1 = 1'b0;
    out_ready1 = 1'b1;
    tick();
    check("t3_release_valid", 32'(out_valid1), 0);
    check("t3_release_ready", 32'(in_ready1), 1);
    check("t3_c_kept",        32'(out_c1), 699678);
    tick();
    check("t3_no_ghost_busy", 32'(busy1), 0);

    // 4: reset during MUL cycle 5 while new operands are offered
    in_a = 12'd100; in_b = 12'd200; in_tag = 8'h44;
    in_valid1 = 1'b1;
    tick();
    in_valid1 = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("t4_busy_before", 32'(busy1), 1);
    reset = 1'b1;
    in_valid1 = 1'b1; in_a = 12'd17; in_b = 12'd19; in_tag = 8'h45;
    tick();
    check("t4_rst_valid", 32'(out_valid1), 0);
    check("t4_rst_c",     32'(out_c1), 0);
    check("t4_rst_tag",   32'(out_tag1), 0);
    check("t4_rst_busy",  32'(busy1), 0);
    check("t4_rst_idle",  32'(in_ready1), 1);
    reset = 1'b0;
    run_op(1, 12'd17, 12'd19, 8'h45, lat);
    check("t4_latency", 32'(lat), 12);
    check("t4_out_c",   32'(out_c1), 323);
    check("t4_out_tag", 32'(out_tag1), 32'h45);
    tick();

    // 5: stream of 8 pairs, in_valid held, random out_ready
    for (int i = 0; i < 8; i++) begin
      a5[i] = 12'($urandom_range(4095, 0));
      b5[i] = 12'($urandom_range(4095, 0));
    end
    idx = 0; got = 0; cyc = 0; last_acc = 0;
    in_a = a5[0]; in_b = b5[0]; in_tag = 8'd0;
    in_valid1 = 1'b1;
    out_ready1 = 1'($urandom_range(1, 0));
    while (got < 8 && cyc < 2000) begin
      acc_now = in_valid1 && in_ready1;
      hs_now  = out_valid1 && out_ready1;
      if (hs_now) begin
        if (exp_q.size() == 0) begin
          check("t5_unexpected_out", 1, 0);
        end else begin
          check("t5_out_c",   32'(out_c1),   32'(exp_q.pop_front()));
          check("t5_out_tag", 32'(out_tag1), 32'(exp_t.pop_front()));
        end
        got++;
      end
      if (acc_now) begin
        exp_q.push_back(24'(a5[idx]) * 24'(b5[idx]));
        exp_t.push_back(8'(idx));
        if (idx > 0) check("t5_accept_spacing", 32'(cyc - last_acc >= 14), 1);
        last_acc = cyc;
        idx++;
      end
      tick();
      cyc++;
      if (acc_now) begin
        if (idx < 8) begin
          in_a = a5[idx]; in_b = b5[idx]; in_tag = 8'(idx);
        end else begin
          in_valid1 = 1'b0;
        end
      end
      out_ready1 = 1'($urandom_range(1, 0));
    end
    check("t5_received", 32'(got), 8);
    check("t5_accepted", 32'(idx), 8);
    out_ready1 = 1'b1;
    check("t5_no_extra_valid", 32'(out_valid1), 0);
    check("t5_idle_after",     32'(in_ready1), 1);

    // 6: 1000 random reduced-range pairs; product and its residue mod q
    for (int i = 0; i < 1000; i++) begin
      ra = 12'($urandom_range(Q - 1, 0));
      rb = 12'($urandom_range(Q - 1, 0));
      exp_c = 24'(ra) * 24'(rb);
      run_op(4, ra, rb, 8'(i), lat);
      check("t6_out_c",  32'(out_c4), 32'(exp_c));
      check("t6_mod_q",  32'(out_c4) % Q, 32'(exp_c) % Q);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/modmul_prod_seq.md
Name: modmul_prod_seq

Overview:
- Iterative, handshaked coefficient multiplier that produces the 24-bit raw product consumed by the combinational 24-to-12-bit mod-q reducer (q = 3329).
- It is the producer (writer) side of the product interface: it accepts two 12-bit coefficients, builds A*B over several cycles by shift-add, then presents the product with a tag until the downstream side accepts it.
- It sits between the coefficient memory read port and the reducer in the polynomial-multiplication datapath.

Parameters:
- RADIX_BITS, 1: multiplier bits of B consumed per cycle. Legal values: 1, 2, 3, 4, 6, 12. Any other value is a synthesis-time error.
- TAG_W, 8: width of the sideband tag (coefficient index) carried alongside each operation.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept an operand pair.
- in_a  input  12  multiplicand A, full range 0..4095.
- in_b  input  12  multiplier B, full range 0..4095.
- in_tag  input  TAG_W  sideband tag, returned unchanged with the product.
- out_valid  output  1  product valid.
- out_ready  input  1  downstream reducer accepts the product.
- out_c  output  24  product A*B, directly feeds the reducer's 24-bit input.
- out_tag  output  TAG_W  tag latched with the operands.
- busy  output  1  high in MUL state.

Behaviour:
- Reset: the already decided scheme applies, a single clock with synchronous active-high reset.
  - On reset, state becomes IDLE, out_valid=0, out_c=0, out_tag=0, busy=0, internal counter=0.
  - Reset overrides every other input in the same cycle. Reset during MUL or OUT aborts the operation; no partial product is ever presented.
- CYCLES = 12/RADIX_BITS.
- States: IDLE, MUL, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch A, B, tag; clear the accumulator; cnt=0; go to MUL.
- MUL:
  - in_ready=0, busy=1.
  - Each cycle: acc += (A * B[cnt*RADIX_BITS +: RADIX_BITS]) << (cnt*RADIX_BITS), LSB slice first; cnt++.
  - After the CYCLES-th accumulation, go to OUT with out_c=acc and out_valid=1.
- OUT:
  - out_valid=1; out_c and out_tag held stable until the handshake.
  - On out_valid&out_ready: go to IDLE and drop out_valid the next cycle.
  - in_ready=0 in OUT. There is no overlap of accept and deliver.
- Latency: operands accepted at edge k; out_valid first high after edge k+CYCLES.
  - Minimum initiation interval is CYCLES+2 cycles (accept, CYCLES MUL cycles, one or more OUT cycles, back through IDLE).
- Arithmetic:
  - Accumulator is 24 bits unsigned with no overflow, since 4095*4095 = 0xFFE001 < 2^24.
  - Partial products are A (12b) times a RADIX_BITS slice.
  - No reduction happens in this block; inputs are not range-checked against q.
- Timing rules:
  - in_valid is ignored while in_ready=0; operands may change freely then.
  - out_ready while out_valid=0 has no effect.
  - out_c and out_tag only change on entry to OUT or on reset. Between those events they keep the last product, so only out_valid qualifies them.
- Counter: cnt width is ceil(log2(CYCLES+1)). It wraps to 0 on entry to MUL.

Test Plan:
1. RADIX_BITS=1: in_a=3328, in_b=3328, tag=0x11, out_ready=1.
   - Required: out_valid high exactly 12 cycles after accept.
   - Required: out_c=0xA90000 (11075584), out_tag=0x11; next cycle out_valid=0, in_ready=1.
2. Maximum operands: in_a=4095, in_b=4095 -> out_c=0xFFE001. Zero operand: in_a=0, in_b=2731 -> out_c=0.
   - Repeat both with RADIX_BITS=4; out_valid must rise 3 cycles after accept.
3. Backpressure: hold out_ready=0 for 20 cycles after out_valid rises.
   - Required: out_c and out_tag stable, in_ready=0 throughout, new in_valid pulses ignored.
   - Release out_ready=1: one transfer, then IDLE.
4. Reset mid-MUL: assert reset at MUL cycle 5 while in_valid is held with new operands (17, 19).
   - Required: state IDLE, out_valid=0, out_c=0.
   - Required: after reset releases, (17, 19) is accepted and out_c=323 after CYCLES cycles.
5. Back-to-back stream: in_valid held high with 8 random operand pairs and tags 0..7, out_ready toggling randomly.
   - Required: every out_c equals in_a*in_b in order, tags 0..7 in order.
   - Required: no duplicates or drops, and spacing of at least CYCLES+2 cycles between accepts.
6. Output feeds the reducer: out_c checked against a mod-3329 golden model.
   - Example: 3328*3328 mod 3329 = 1.
   - Required: the reducer output matches (A*B) mod 3329 for 1000 random pairs with A, B < 3329.
